// File: rtl/writeback_scoreboard.sv
// Write-back stage with a per-register pending-write scoreboard.
// ID reserves a destination register at issue; the retiring instruction is
// written back one cycle later through a registered register-file port, and
// the reservation is released on the edge that ends the write pulse. The
// decoder reads the busy flags to detect read-after-write hazards.
module writeback_scoreboard #(
   parameter int CNT_W = 2,
   parameter int NREG  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic             issue_reg_write,
   input  logic [4:0]       issue_rd,
   output logic             issue_ready,
   input  logic [4:0]       src_addr1,
   input  logic [4:0]       src_addr2,
   output logic             hazard,
   input  logic             ret_valid,
   input  logic             ret_reg_write,
   input  logic             mem_to_reg,
   input  logic [4:0]       ret_rd,
   input  logic [31:0]      alu_data_out,
   input  logic [31:0]      mem_data_out,
   output logic             reg_write,
   output logic [4:0]       reg_wr_addr_wb,
   output logic [31:0]      reg_wr_data,
   output logic [NREG-1:0]  reg_busy,
   output logic             sb_error
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt [NREG];
   logic             res;
   logic             cap;
   logic             underflow;
   logic [NREG-1:0]  inc_vec;
   logic [NREG-1:0]  dec_vec;

   // Reservation acceptance and the qualified issue / retire strobes.
   always_comb begin
      issue_ready = (cnt[issue_rd] != CNT_MAX) || (issue_rd == 5'd0);
      res         = issue_valid && issue_reg_write && (issue_rd != 5'd0) && issue_ready;
      cap         = ret_valid && ret_reg_write && (ret_rd != 5'd0);
      // A write pulse never targets r0, so reg_write alone qualifies the release.
      underflow   = reg_write && (cnt[reg_wr_addr_wb] == '0);
   end

   // Per-register increment/decrement requests; busy flags and hazard detect.
   always_comb begin
      // NOTE: every output of this block gets a default before the loop, so
      // no path leaves a bit unassigned and no latch can be inferred.
      inc_vec  = '0;
      dec_vec  = '0;
      reg_busy = '0;
      for (int i = 1; i < NREG; i++) begin
         inc_vec[i]  = res && (issue_rd == 5'(i));
         // A release at count 0 is dropped here and reported as underflow.
         dec_vec[i]  = reg_write && (reg_wr_addr_wb == 5'(i)) && (cnt[i] != '0);
         reg_busy[i] = (cnt[i] != '0);
      end
      hazard = ((src_addr1 != 5'd0) && reg_busy[src_addr1]) ||
               ((src_addr2 != 5'd0) && reg_busy[src_addr2]);
   end

   // Pending-write counters and the sticky underflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the counter array is cleared explicitly because a stale
         // count would leave a register busy forever; this is deliberate,
         // not a generic habit of resetting every memory.
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= '0;
         end
         sb_error <= 1'b0;
      end else begin
         // Increment is blocked at max by issue_ready and decrement is blocked
         // at zero above, so the sum never wraps; both together cancel out.
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= cnt[i] + CNT_W'(inc_vec[i]) - CNT_W'(dec_vec[i]);
         end
         sb_error <= sb_error || underflow;
      end
   end

   // Registered register-file write port; address and data hold when idle.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      if (reset) begin
         reg_write      <= 1'b0;
         reg_wr_addr_wb <= 5'd0;
         reg_wr_data    <= 32'd0;
      end else begin
         reg_write <= cap;
         if (cap) begin
            reg_wr_addr_wb <= ret_rd;
            reg_wr_data    <= mem_to_reg ? mem_data_out : alu_data_out;
         end
      end
   end

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed bench for writeback_scoreboard. Expected register-file writes are
// queued at retire time and checked by an independent monitor; scoreboard
// flags are checked directly against hand-computed values.
module tb_writeback_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid, issue_reg_write;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [4:0]  src_addr1, src_addr2;
   logic        hazard;
   logic        ret_valid, ret_reg_write, mem_to_reg;
   logic [4:0]  ret_rd;
   logic [31:0] alu_data_out, mem_data_out;
   logic        reg_write;
   logic [4:0]  reg_wr_addr_wb;
   logic [31:0] reg_wr_data;
   logic [31:0] reg_busy;
   logic        sb_error;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_t;

   wb_t exp_q[$];
   int  vectors     = 0;
   int  miscompares = 0;

   writeback_scoreboard #(.CNT_W(2), .NREG(32)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_reg_write(issue_reg_write),
      .issue_rd(issue_rd), .issue_ready(issue_ready),
      .src_addr1(src_addr1), .src_addr2(src_addr2), .hazard(hazard),
      .ret_valid(ret_valid), .ret_reg_write(ret_reg_write),
      .mem_to_reg(mem_to_reg), .ret_rd(ret_rd),
      .alu_data_out(alu_data_out), .mem_data_out(mem_data_out),
      .reg_write(reg_write), .reg_wr_addr_wb(reg_wr_addr_wb),
      .reg_wr_data(reg_wr_data), .reg_busy(reg_busy), .sb_error(sb_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_valid     = 1'b1;
      issue_reg_write = 1'b1;
      issue_rd        = rd;
   endtask

   task automatic retire(input logic [4:0] rd, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] mem);
      ret_valid     = 1'b1;
      ret_reg_write = 1'b1;
      ret_rd        = rd;
      mem_to_reg    = m2r;
      alu_data_out  = alu;
      mem_data_out  = mem;
      if (rd != 5'd0) exp_q.push_back('{addr: rd, data: (m2r ? mem : alu)});
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      ret_valid   = 1'b0;
   endtask

   // Monitor: every write pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && reg_write) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", 32'(reg_wr_addr_wb), 32'hFFFF_FFFF);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            check("wb_addr", 32'(reg_wr_addr_wb), 32'(e.addr));
            check("wb_data", reg_wr_data, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      issue_valid = 0; issue_reg_write = 0; issue_rd = 0;
      src_addr1 = 0; src_addr2 = 0;
      ret_valid = 0; ret_reg_write = 0; mem_to_reg = 0; ret_rd = 0;
      alu_data_out = 0; mem_data_out = 0;
      step(); step();
      reset = 1'b0;
      issue_rd = 5'd5;
      step();
      check("rst_busy",   reg_busy, 32'h0);
      check("rst_wr",     32'(reg_write), 32'd0);
      check("rst_hazard", 32'(hazard), 32'd0);
      check("rst_err",    32'(sb_error), 32'd0);
      check("rst_ready",  32'(issue_ready), 32'd1);

      // Reserve r5, see the hazard, retire it and watch the flag clear late.
      issue(5'd5); step(); idle();
      src_addr1 = 5'd5; #1;
      check("r5_hazard", 32'(hazard), 32'd1);
      retire(5'd5, 1'b0, 32'h0000_00AA, 32'h1234_5678); step(); idle();
      check("r5_wr_pulse",   32'(reg_write), 32'd1);
      check("r5_still_busy", 32'(reg_busy[5]), 32'd1);
      check("r5_no_bypass",  32'(hazard), 32'd1);
      step();
      check("r5_released", 32'(reg_busy[5]), 32'd0);
      check("r5_hazard_0", 32'(hazard), 32'd0);
      check("r5_wr_drop",  32'(reg_write), 32'd0);
      src_addr1 = 5'd0;

      // Saturate r7; a further issue is refused without wrapping the count.
      issue(5'd7); step(); step(); step();
      issue_rd = 5'd7; #1;
      check("r7_full_ready", 32'(issue_ready), 32'd0);
      step(); idle();
      issue_rd = 5'd8; #1;
      check("r8_ready", 32'(issue_ready), 32'd1);
      retire(5'd7, 1'b0, 32'h0000_0077, 32'h0); step(); idle(); step();
      issue_rd = 5'd7; #1;
      check("r7_ready_again", 32'(issue_ready), 32'd1);
      check("r7_busy_cnt2",   32'(reg_busy[7]), 32'd1);
      check("r7_no_underflow", 32'(sb_error), 32'd0);

      // Load-data select and underflow on an unreserved register.
      retire(5'd9, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF); step(); idle(); step();
      check("r9_underflow", 32'(sb_error), 32'd1);
      check("r9_not_busy",  32'(reg_busy[9]), 32'd0);
      step();
      check("err_sticky", 32'(sb_error), 32'd1);

      // Reserve and release r3 on the same edge while its count is 1.
      issue(5'd3); step(); idle();
      retire(5'd3, 1'b0, 32'h0000_0033, 32'h0); step(); idle();
      issue(5'd3); step(); idle();
      src_addr2 = 5'd3; #1;
      check("r3_busy_same_edge", 32'(reg_busy[3]), 32'd1);
      check("r3_hazard_src2",    32'(hazard), 32'd1);
      step();
      check("r3_busy_after", 32'(reg_busy[3]), 32'd1);
      src_addr2 = 5'd0;

      // r0 is never reserved, written or busy.
      issue(5'd0); retire(5'd0, 1'b0, 32'hFFFF_0000, 32'h0); #1;
      check("r0_ready", 32'(issue_ready), 32'd1);
      step(); idle();
      check("r0_no_write", 32'(reg_write), 32'd0);
      check("r0_not_busy", 32'(reg_busy[0]), 32'd0);
      check("r0_hazard",   32'(hazard), 32'd0);

      // Reset in the middle of traffic with cnt[4]=2.
      issue(5'd4); step(); step(); idle();
      check("r4_busy", 32'(reg_busy[4]), 32'd1);
      issue(5'd4); retire(5'd4, 1'b0, 32'h0000_0044, 32'h0);
      exp_q.delete();
      reset = 1'b1; step(); reset = 1'b0; idle();
      check("mid_rst_busy", reg_busy, 32'h0);
      check("mid_rst_wr",   32'(reg_write), 32'd0);
      check("mid_rst_addr", 32'(reg_wr_addr_wb), 32'd0);
      check("mid_rst_data", reg_wr_data, 32'd0);
      check("mid_rst_err",  32'(sb_error), 32'd0);
      step(); step();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/writeback_scoreboard.md
Name: writeback_scoreboard

Overview:
- Write-back stage with the register busy-flag scoreboard that the instruction decoder consults before it reads the register file.
- At issue from ID, the destination register is reserved (its pending count is incremented).
- On retire from MEM/WB, the block selects ALU or memory data and drives one registered register-file write: reg_write, reg_wr_addr_wb and reg_wr_data.
- After the write it releases the reservation and reports read-after-write hazards for the two source addresses being decoded.

Parameters:
- CNT_W, 2: width of the per-register pending-write counter. At most 2^CNT_W-1 writes can be outstanding per register.
- NREG, 32: number of architectural registers. Register 0 is hardwired to zero.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  ID is issuing an instruction this cycle
- issue_reg_write  in  1  the issuing instruction writes a register (reg_write_cu)
- issue_rd  in  5  destination register of the issuing instruction
- issue_ready  out  1  reservation can be accepted (combinational)
- src_addr1  in  5  rs address being decoded
- src_addr2  in  5  rt address being decoded
- hazard  out  1  rs or rt has a pending write (combinational)
- ret_valid  in  1  MEM/WB holds a retiring instruction
- ret_reg_write  in  1  the retiring instruction writes a register
- mem_to_reg  in  1  1 selects mem_data_out, 0 selects alu_data_out
- ret_rd  in  5  destination register of the retiring instruction
- alu_data_out  in  32  ALU result
- mem_data_out  in  32  load data
- reg_write  out  1  register-file write enable (registered)
- reg_wr_addr_wb  out  5  register-file write address (registered)
- reg_wr_data  out  32  register-file write data (registered)
- reg_busy  out  NREG  bit i is 1 when the pending count of register i is non-zero
- sb_error  out  1  sticky error flag; set on counter underflow

Behaviour:
- Reset, synchronous: all counters are 0.
  - reg_write=0, reg_wr_addr_wb=0, reg_wr_data=0, sb_error=0, reg_busy=0.
  - Reset overrides every simultaneous issue or retire, including one in the middle of an operation.
- Reservation: res = issue_valid & issue_reg_write & issue_rd!=0 & issue_ready.
  - issue_ready = (cnt[issue_rd] != max) OR (issue_rd == 0).
  - When issue_ready is 0, ID must hold the instruction. An issue presented while not ready is ignored, with no state change.
- Retire capture: cap = ret_valid & ret_reg_write & ret_rd!=0, sampled at posedge.
  - Next cycle: reg_write=1, reg_wr_addr_wb=ret_rd, reg_wr_data = mem_to_reg ? mem_data_out : alu_data_out.
  - When cap=0: reg_write=0, and addr/data hold their previous values.
- Latency: 1 cycle from the retire sample to reg_write asserted.
- Release: at the posedge where reg_write==1, cnt[reg_wr_addr_wb] is decremented.
  - The flag therefore clears one cycle after the write pulse, when the register file already holds the new value.
  - The decoder never sees a flag clear before the data is available.
- Release at count 0 is an underflow: the count stays at 0 and sb_error is set to 1, sticky until reset.
- Reservation and release on the same register at the same edge: net count unchanged.
- Reservation and release on different registers at the same edge: both are applied independently.
- hazard = (src_addr1!=0 & reg_busy[src_addr1]) | (src_addr2!=0 & reg_busy[src_addr2]).
  - It is purely combinational from the registered counters.
  - No bypass: a release at the current edge becomes visible only in the next cycle.
- Register 0 is never reserved, never written and never busy. A retire targeting r0 produces reg_write=0.
- Counter arithmetic is unsigned CNT_W bits and never wraps:
  - saturation at max is prevented by issue_ready;
  - underflow is prevented by the sb_error rule.

Test Plan:
- Reset for 2 cycles, then idle → reg_busy=0, reg_write=0, hazard=0, sb_error=0, issue_ready=1.
- Issue rd=5, then decode src1=5 → hazard=1. Retire rd=5 with mem_to_reg=0, alu=0x0000_00AA → next cycle reg_write=1, addr=5, data=0xAA; one cycle later reg_busy[5]=0 and hazard=0.
- Issue rd=7 three times with CNT_W=2 → issue_ready=0 for rd=7 while issue_ready stays 1 for rd=8. Retire rd=7 once → cnt[7]=2 and issue_ready returns to 1.
- Retire rd=9 with mem_to_reg=1, mem=0xDEAD_BEEF, alu=0x1 → reg_wr_data=0xDEADBEEF. With no prior reservation: sb_error=1 and cnt[9] stays 0.
- Reserve and release rd=3 on the same edge while cnt[3]=1 → cnt[3] stays 1 and reg_busy[3] stays 1.
- Issue and retire with rd=0 → reg_write=0, reg_busy[0]=0, hazard=0 for src1=0. Assert reset mid-stream with cnt[4]=2 → all counters 0 and reg_write=0 on the next cycle.
